sobel_edge_detect: RTL and testbench

- Consumes the 3x3 window stream of the matrix-generation stage (nine 8-bit pixels plus vsync/href/clken sync) and computes the Sobel gradient magnitude and a binary edge flag per pixel.
- Fixed 3-cycle pipeline; the sync signals are delayed to match.
- Border windows (first two columns and first two rows of a frame) are forced to zero.
- Output feeds the display/binarisation back end.

---
 rtl/sobel_edge_detect.sv | 144 ++++++++++++++
 tb/tb_sobel_edge_detect.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_detect.sv
// Sobel gradient stage: 3x3 window in, saturated |Gx|+|Gy| magnitude and edge flag out.
// Fixed 3-cycle pipeline with matching sync delay and first-two-row/column blanking.
module sobel_edge_detect #(
    parameter int IMG_HDISP    = 320,
    parameter int IMG_VDISP    = 240,
    parameter bit BORDER_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       matrix_frame_vsync,
    input  logic       matrix_frame_href,
    input  logic       matrix_frame_clken,
    input  logic [7:0] matrix_p11,
    input  logic [7:0] matrix_p12,
    input  logic [7:0] matrix_p13,
    input  logic [7:0] matrix_p21,
    input  logic [7:0] matrix_p22,
    input  logic [7:0] matrix_p23,
    input  logic [7:0] matrix_p31,
    input  logic [7:0] matrix_p32,
    input  logic [7:0] matrix_p33,
    input  logic [7:0] edge_threshold,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_mag,
    output logic       post_img_bit
);
    localparam int DIM_MAX     = (IMG_HDISP > IMG_VDISP) ? IMG_HDISP : IMG_VDISP;
    localparam int CNT_SAT_VAL = 1023;
    localparam int CNT_W       = $clog2(((DIM_MAX > CNT_SAT_VAL) ? DIM_MAX : CNT_SAT_VAL) + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_SAT_VAL);

    // The Sobel kernels have a zero centre tap, so p22 never contributes.
    logic unused_p22;
    assign unused_p22 = ^matrix_p22;

    // Sync delay line {vsync, href, clken}; stage gi holds the input delayed gi+1 clocks.
    logic [2:0] sync_in;
    assign sync_in = {matrix_frame_vsync, matrix_frame_href, matrix_frame_clken};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic [2:0] stage_reg;
            logic [2:0] stage_next;
            if (gi == 0) begin : g_head
                assign stage_next = sync_in;
            end else begin : g_tail
                assign stage_next = g_sync[gi-1].stage_reg;
            end
            always_ff @(posedge clk) begin
                if (rst) stage_reg <= '0;
                else     stage_reg <= stage_next;
            end
        end
    endgenerate

    logic href_d1, vsync_d1, href_d2;
    assign vsync_d1 = g_sync[0].stage_reg[2];
    assign href_d1  = g_sync[0].stage_reg[1];
    assign href_d2  = g_sync[1].stage_reg[1];

    // Position counters on the input side; they decide whether a window touches the border.
    logic [CNT_W-1:0] col_cnt_reg, row_cnt_reg;
    logic             href_fall, vsync_rise, inside_next;
    assign href_fall   = href_d1 & ~matrix_frame_href;
    assign vsync_rise  = matrix_frame_vsync & ~vsync_d1;
    assign inside_next = (col_cnt_reg >= CNT_W'(2)) && (row_cnt_reg >= CNT_W'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
        end else begin
            if (!matrix_frame_href)
                col_cnt_reg <= '0;
            else if (matrix_frame_clken && col_cnt_reg != CNT_SAT)
                col_cnt_reg <= col_cnt_reg + CNT_W'(1);
            if (vsync_rise)
                row_cnt_reg <= '0;
            else if (href_fall && row_cnt_reg != CNT_SAT)
                row_cnt_reg <= row_cnt_reg + CNT_W'(1);
        end
    end

    // Stage 1: weighted positive/negative column and row sums.
    logic [9:0] gx_p_next, gx_n_next, gy_p_next, gy_n_next;
    logic [9:0] gx_p_reg, gx_n_reg, gy_p_reg, gy_n_reg;
    logic       inside_s1_reg, inside_s2_reg;
    assign gx_p_next = {2'b00, matrix_p13} + {1'b0, matrix_p23, 1'b0} + {2'b00, matrix_p33};
    assign gx_n_next = {2'b00, matrix_p11} + {1'b0, matrix_p21, 1'b0} + {2'b00, matrix_p31};
    assign gy_p_next = {2'b00, matrix_p31} + {1'b0, matrix_p32, 1'b0} + {2'b00, matrix_p33};
    assign gy_n_next = {2'b00, matrix_p11} + {1'b0, matrix_p12, 1'b0} + {2'b00, matrix_p13};

    // Stage 2: signed difference, then absolute value (fits in 10 bits, max 1020).
    logic signed [10:0] gx_diff, gy_diff;
    logic [9:0]         gx_abs_next, gy_abs_next, gx_abs_reg, gy_abs_reg;
    assign gx_diff     = $signed({1'b0, gx_p_reg}) - $signed({1'b0, gx_n_reg});
    assign gy_diff     = $signed({1'b0, gy_p_reg}) - $signed({1'b0, gy_n_reg});
    assign gx_abs_next = gx_diff[10] ? 10'(-gx_diff) : gx_diff[9:0];
    assign gy_abs_next = gy_diff[10] ? 10'(-gy_diff) : gy_diff[9:0];

    // Stage 3: sum, saturate, gate and threshold.
    logic [10:0] mag_sum;
    logic [7:0]  mag_sat, mag_next, mag_reg;
    logic        pass, bit_next, bit_reg;
    assign mag_sum  = {1'b0, gx_abs_reg} + {1'b0, gy_abs_reg};
    assign mag_sat  = (mag_sum > 11'd255) ? 8'd255 : mag_sum[7:0];
    assign pass     = href_d2 && (!BORDER_BLANK || inside_s2_reg);
    assign mag_next = pass ? mag_sat : 8'd0;
    assign bit_next = pass && (mag_sat > edge_threshold);

    always_ff @(posedge clk) begin
        if (rst) begin
            gx_p_reg      <= '0;
            gx_n_reg      <= '0;
            gy_p_reg      <= '0;
            gy_n_reg      <= '0;
            inside_s1_reg <= 1'b0;
            gx_abs_reg    <= '0;
            gy_abs_reg    <= '0;
            inside_s2_reg <= 1'b0;
            mag_reg       <= '0;
            bit_reg       <= 1'b0;
        end else begin
            gx_p_reg      <= gx_p_next;
            gx_n_reg      <= gx_n_next;
            gy_p_reg      <= gy_p_next;
            gy_n_reg      <= gy_n_next;
            inside_s1_reg <= inside_next;
            gx_abs_reg    <= gx_abs_next;
            gy_abs_reg    <= gy_abs_next;
            inside_s2_reg <= inside_s1_reg;
            mag_reg       <= mag_next;
            bit_reg       <= bit_next;
        end
    end

    assign post_frame_vsync = g_sync[2].stage_reg[2];
    assign post_frame_href  = g_sync[2].stage_reg[1];
    assign post_frame_clken = g_sync[2].stage_reg[0];
    assign post_img_mag     = mag_reg;
    assign post_img_bit     = bit_reg;
endmodule

// File: tb/tb_sobel_edge_detect.sv
// Directed bench for sobel_edge_detect: one blanked and one raw (BORDER_BLANK=0) instance
// share the same stimulus; hand-computed windows plus a small Sobel reference for frames.
module tb_sobel_edge_detect;
    logic       clk = 1'b0;
    logic       rst;
    logic       vsync, href, clken;
    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic [7:0] thr;
    logic       o_vsync, o_href, o_clken, o_bit;
    logic [7:0] o_mag;
    logic       r_vsync, r_href, r_clken, r_bit;
    logic [7:0] r_mag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic sb_on = 1'b0;

    // Per-cycle input history and expected results, checked three cycles later.
    logic       h_v [2048], h_h [2048], h_c [2048], h_sb [2048], h_chk [2048];
    logic [7:0] e_mag [2048], e_raw [2048];
    logic       e_bit [2048], e_rbit [2048];
    logic       cur_chk = 1'b0, cur_bit = 1'b0, cur_rbit = 1'b0;
    logic [7:0] cur_mag = 8'd0, cur_raw = 8'd0;

    localparam logic [71:0] UNI  = {9{8'd100}};
    localparam logic [71:0] E200 = {8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd200};
    localparam logic [71:0] E10  = {8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10};
    localparam logic [71:0] DIAG = {64'd0, 8'd255};

    always #5 clk = ~clk;

    sobel_edge_detect #(.IMG_HDISP(320), .IMG_VDISP(240), .BORDER_BLANK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .matrix_frame_vsync(vsync), .matrix_frame_href(href), .matrix_frame_clken(clken),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
        .edge_threshold(thr),
        .post_frame_vsync(o_vsync), .post_frame_href(o_href), .post_frame_clken(o_clken),
        .post_img_mag(o_mag), .post_img_bit(o_bit)
    );

    sobel_edge_detect #(.IMG_HDISP(320), .IMG_VDISP(240), .BORDER_BLANK(1'b0)) dut_raw (
        .clk(clk), .rst(rst),
        .matrix_frame_vsync(vsync), .matrix_frame_href(href), .matrix_frame_clken(clken),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
        .edge_threshold(thr),
        .post_frame_vsync(r_vsync), .post_frame_href(r_href), .post_frame_clken(r_clken),
        .post_img_mag(r_mag), .post_img_bit(r_bit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_win(input logic [71:0] w);
        {p11, p12, p13, p21, p22, p23, p31, p32, p33} = w;
    endtask

    function automatic logic [7:0] img(input int r, input int c);
        if (r < 0 || c < 0) return 8'd0;
        return 8'(r * 30 + c * 20);
    endfunction

    function automatic logic [71:0] win_at(input int r, input int c);
        return {img(r-2, c-2), img(r-2, c-1), img(r-2, c),
                img(r-1, c-2), img(r-1, c-1), img(r-1, c),
                img(r,   c-2), img(r,   c-1), img(r,   c)};
    endfunction

    function automatic logic [7:0] sobel(input logic [71:0] w);
        int a11, a12, a13, a21, a23, a31, a32, a33, gx, gy, m;
        a11 = int'(w[71:64]); a12 = int'(w[63:56]); a13 = int'(w[55:48]);
        a21 = int'(w[47:40]); a23 = int'(w[31:24]);
        a31 = int'(w[23:16]); a32 = int'(w[15:8]);  a33 = int'(w[7:0]);
        gx = (a13 + 2*a23 + a33) - (a11 + 2*a21 + a31);
        gy = (a31 + 2*a32 + a33) - (a11 + 2*a12 + a13);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = gx + gy;
        return (m > 255) ? 8'd255 : 8'(m);
    endfunction

    task automatic step();
        int i;
        i = cyc & 2047;
        h_v[i] = vsync; h_h[i] = href; h_c[i] = clken; h_sb[i] = sb_on; h_chk[i] = cur_chk;
        e_mag[i] = cur_mag; e_bit[i] = cur_bit; e_raw[i] = cur_raw; e_rbit[i] = cur_rbit;
        @(posedge clk);
        #1;
        cyc++;
        if (sb_on && cyc >= 3) begin
            i = (cyc - 3) & 2047;
            if (h_sb[i]) begin
                check("sync_vsync", o_vsync, h_v[i]);
                check("sync_href", o_href, h_h[i]);
                check("sync_clken", o_clken, h_c[i]);
                if (h_chk[i]) begin
                    check("blank_mag", o_mag, e_mag[i]);
                    check("blank_bit", o_bit, e_bit[i]);
                    check("raw_mag", r_mag, e_raw[i]);
                    check("raw_bit", r_bit, e_rbit[i]);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        vsync = 1'b0; href = 1'b0; clken = 1'b0; cur_chk = 1'b0;
        repeat (n) step();
    endtask

    task automatic start_frame();
        vsync = 1'b1; href = 1'b0; clken = 1'b0; cur_chk = 1'b0;
        repeat (2) step();
        vsync = 1'b0;
        repeat (2) step();
    endtask

    // One href-high segment of 'width' pixels, a clken every 'stride' clocks, then 'gap' idle clocks.
    task automatic line(input int r, input int width, input int stride, input int gap);
        int c, k;
        logic [71:0] w;
        c = 0; k = 0;
        href = 1'b1;
        while (c < width) begin
            if (k % stride == 0) begin
                w = win_at(r, c);
                set_win(w);
                cur_raw  = sobel(w);
                cur_mag  = (r >= 2 && c >= 2) ? cur_raw : 8'd0;
                cur_bit  = cur_mag > thr;
                cur_rbit = cur_raw > thr;
                cur_chk  = 1'b1;
                clken    = 1'b1;
                c++;
            end else begin
                clken   = 1'b0;
                cur_chk = 1'b0;
            end
            step();
            k++;
        end
        href = 1'b0; clken = 1'b0; cur_chk = 1'b0;
        repeat (gap) step();
    endtask

    // Single strobed window followed by held cycles; checks the output just before and at +3 clk.
    task automatic pix(input string tag, input logic [71:0] w, input logic [7:0] t,
                       input logic [7:0] pre, input logic [7:0] em, input logic eb,
                       input logic [7:0] er);
        set_win(w); thr = t; clken = 1'b1;
        step();
        clken = 1'b0;
        step();
        check({tag, "_pre_mag"}, o_mag, pre);
        check({tag, "_pre_clken"}, o_clken, 0);
        step();
        check({tag, "_clken"}, o_clken, 1);
        check({tag, "_mag"}, o_mag, em);
        check({tag, "_bit"}, o_bit, eb);
        check({tag, "_raw_mag"}, r_mag, er);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mag"}, o_mag, 0);
        check({tag, "_bit"}, o_bit, 0);
        check({tag, "_vsync"}, o_vsync, 0);
        check({tag, "_href"}, o_href, 0);
        check({tag, "_clken"}, o_clken, 0);
        check({tag, "_raw_mag"}, r_mag, 0);
        check({tag, "_raw_vsync"}, r_vsync, 0);
        check({tag, "_raw_href"}, r_href, 0);
        check({tag, "_raw_clken"}, r_clken, 0);
    endtask

    initial begin
        // Reset with busy inputs: everything must stay at zero.
        rst = 1'b1; vsync = 1'b1; href = 1'b1; clken = 1'b1; thr = 8'd0;
        set_win(E200);
        repeat (2) step();
        check_zero("reset");
        rst = 1'b0;
        set_win(UNI);
        idle(3);

        // Two lines to reach row 2, then single-window directed cases on line 2.
        thr = 8'd128;
        sb_on = 1'b1;
        start_frame();
        line(0, 4, 1, 2);
        line(1, 4, 1, 2);
        sb_on = 1'b0;
        set_win(UNI); href = 1'b1; clken = 1'b0;
        repeat (3) step();
        pix("col0_border", E200, 8'd128, 8'd0,   8'd0,   1'b0, 8'd255);
        pix("col1_border", E200, 8'd128, 8'd0,   8'd0,   1'b0, 8'd255);
        pix("vert_sat",    E200, 8'd128, 8'd255, 8'd255, 1'b1, 8'd255);
        pix("vert_eq",     E10,  8'd40,  8'd255, 8'd40,  1'b0, 8'd40);
        pix("uniform",     UNI,  8'd0,   8'd40,  8'd0,   1'b0, 8'd0);
        pix("diag",        DIAG, 8'd0,   8'd0,   8'd255, 1'b1, 8'd255);
        thr = 8'd60;
        idle(4);

        // 8x4 ramp frame, continuous clken.
        sb_on = 1'b1;
        start_frame();
        for (int r = 0; r < 4; r++) line(r, 8, 1, 2);
        idle(4);

        // Sparse clken and an href drop mid-line: column count restarts after the gap.
        start_frame();
        line(0, 8, 3, 2);
        line(1, 8, 3, 2);
        line(2, 4, 3, 5);
        line(3, 4, 3, 2);
        line(4, 8, 3, 2);
        idle(4);

        // Reset mid-line with data in flight, then a clean frame.
        start_frame();
        line(0, 6, 1, 2);
        line(1, 6, 1, 2);
        line(2, 5, 1, 0);
        sb_on = 1'b0;
        rst = 1'b1; href = 1'b1; clken = 1'b1;
        step();
        check_zero("mid_reset");
        rst = 1'b0;
        idle(3);
        sb_on = 1'b1;
        start_frame();
        for (int r = 0; r < 4; r++) line(r, 8, 1, 2);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
